// File: rtl/chip_invaders_pkg.sv
// chip_invaders_pkg: shared sprite state type and sprite dimensions in scale units
package chip_invaders_pkg;
    typedef enum logic [1:0] {IDLE, FALLING, EXPLODING} bomb_state_t;
    localparam int CANNON_W_UNITS = 13;
    localparam int BOMB_W_UNITS = 1;
    localparam int BOMB_H_UNITS = 3;
endpackage

// File: rtl/alien_bomb_slot.sv
// alien_bomb_slot: one bomb slot - falls per frame, collides, explodes and draws itself
module alien_bomb_slot
    import chip_invaders_pkg::*;
#(
    parameter int CANNON_Y = 470,
    parameter int LOWER_BORDER = 480,
    parameter int SCALING = 4,
    parameter int BOMB_SPEED = 2,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [9:0] cannon_x,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       hit_shield,
    output logic       idle,
    output logic       falling,
    output logic       cannon_hit,
    output logic       pixel
);
    localparam int CW = $clog2(EXPLODE_FRAMES + 2);
    localparam logic [10:0] BOMB_W = 11'(BOMB_W_UNITS * SCALING);
    localparam logic [10:0] BOMB_H = 11'(BOMB_H_UNITS * SCALING);
    localparam logic [10:0] CANNON_W = 11'(CANNON_W_UNITS * SCALING);
    localparam logic [10:0] BLAST_L = 11'(SCALING);
    localparam logic [10:0] BLAST_R = 11'(2 * SCALING);
    localparam logic [10:0] SPEED = 11'(BOMB_SPEED);
    localparam logic [10:0] CANNON_TOP = 11'(CANNON_Y);
    localparam logic [10:0] BOTTOM = 11'(LOWER_BORDER);

    bomb_state_t state, state_n;
    logic [9:0] x, y, x_n, y_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [10:0] x11, y11, cx11, h11, v11, blast_left;
    logic over_cannon, in_rows;

    // all arithmetic is 11 bits wide so sums near the bottom of the screen never wrap
    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};
    assign cx11 = {1'b0, cannon_x};
    assign h11 = {1'b0, hpos};
    assign v11 = {1'b0, vpos};
    assign over_cannon = (y11 + BOMB_H >= CANNON_TOP) && (x11 < cx11 + CANNON_W) && (x11 + BOMB_W > cx11);
    assign cannon_hit = tick && state == FALLING && !hit_shield && over_cannon;
    assign idle = state == IDLE;
    assign falling = state == FALLING;
    assign blast_left = x11 >= BLAST_L ? x11 - BLAST_L : '0;
    assign in_rows = v11 >= y11 && v11 < y11 + BOMB_H;
    assign pixel = in_rows && ((state == FALLING && h11 >= x11 && h11 < x11 + BOMB_W) ||
                               (state == EXPLODING && h11 >= blast_left && h11 < x11 + BLAST_R));

    // slot state, position and explosion counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            x <= x_n;
            y <= y_n;
            cnt <= cnt_n;
        end
    end

    // per-frame transitions: shield beats cannon, cannon beats leaving the playfield
    always_comb begin
        state_n = state;
        x_n = x;
        y_n = y;
        cnt_n = cnt;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state_n = FALLING;
                        x_n = load_x;
                        y_n = load_y;
                    end
                end
                FALLING: begin
                    if (hit_shield || over_cannon) begin
                        state_n = EXPLODING;
                        cnt_n = CW'(EXPLODE_FRAMES);
                    end else if (y11 + SPEED >= BOTTOM) begin
                        state_n = IDLE;
                    end else begin
                        y_n = 10'(y11 + SPEED);
                    end
                end
                EXPLODING: begin
                    cnt_n = cnt - 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_n = IDLE;
                        cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: pool of alien bomb slots with spawn allocation, cooldown, cannon hit and graphics merge
module alien_bomb
    import chip_invaders_pkg::*;
#(
    parameter int NUM_BOMBS = 3,
    parameter int CANNON_Y = 470,
    parameter int LOWER_BORDER = 480,
    parameter int SCALING = 4,
    parameter int BOMB_SPEED = 2,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int EXPLODE_FRAMES = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [9:0]           vpos,
    input  logic [9:0]           hpos,
    input  logic                 vsync,
    input  logic                 enable,
    input  logic                 spawn_valid,
    input  logic [9:0]           spawn_x,
    input  logic [9:0]           spawn_y,
    output logic                 spawn_ready,
    input  logic [9:0]           cannon_x,
    input  logic [NUM_BOMBS-1:0] hit_shield,
    output logic                 cannon_hit,
    output logic [NUM_BOMBS-1:0] bombs_active,
    output logic                 bomb_gfx
);
    localparam int CDW = $clog2(COOLDOWN_FRAMES + 2);
    // the spawn frame itself counts as the first cooldown frame, so accepts are exactly COOLDOWN_FRAMES apart
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES > 0 ? COOLDOWN_FRAMES - 1 : 0);

    logic vsync_q, frame_tick, accept;
    logic [CDW-1:0] cooldown;
    logic [NUM_BOMBS-1:0] idle, grant, load, hits, pixels;

    assign frame_tick = reset_n && vsync && !vsync_q;
    assign spawn_ready = frame_tick && enable && cooldown == '0 && |idle;
    assign accept = spawn_valid && spawn_ready;
    assign grant = idle & (~idle + 1'b1);
    assign load = accept ? grant : '0;

    // frame edge detect, spawn cooldown and registered hit/graphics outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            cooldown <= '0;
            cannon_hit <= 1'b0;
            bomb_gfx <= 1'b0;
        end else begin
            vsync_q <= vsync;
            cannon_hit <= |hits;
            bomb_gfx <= |pixels;
            if (frame_tick)
                cooldown <= accept ? CD_LOAD : (cooldown != '0 ? cooldown - 1'b1 : cooldown);
        end
    end

    for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
        alien_bomb_slot #(
            .CANNON_Y(CANNON_Y),
            .LOWER_BORDER(LOWER_BORDER),
            .SCALING(SCALING),
            .BOMB_SPEED(BOMB_SPEED),
            .EXPLODE_FRAMES(EXPLODE_FRAMES)
        ) u_slot (
            .clock(clock),
            .reset_n(reset_n),
            .tick(frame_tick),
            .load(load[i]),
            .load_x(spawn_x),
            .load_y(spawn_y),
            .cannon_x(cannon_x),
            .hpos(hpos),
            .vpos(vpos),
            .hit_shield(hit_shield[i]),
            .idle(idle[i]),
            .falling(bombs_active[i]),
            .cannon_hit(hits[i]),
            .pixel(pixels[i])
        );
    end
endmodule
